fuzzy_risk: RTL and testbench
=============================

Name: fuzzy_risk

Overview:
- Mamdani-style fuzzy inference core. Takes rainfall and soil-moisture percentages (0..100) and produces an 8-bit risk score (0..255).
- Sits behind the sensor-sampling controller. That controller pulses `ef` once both inputs have been latched.
- One computation per `ef` pulse: fuzzify, evaluate a 9-rule base with min/max, then defuzzify by weighted average using a sequential divider.

Parameters:
- IN_MAX, 100, clamp ceiling applied to both inputs.
- RISK_LOW, 40, output singleton for the Low risk class.
- RISK_MED, 128, output singleton for the Medium risk class.
- RISK_HIGH, 230, output singleton for the High risk class.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ef  input  1  enable/start pulse; sampled on the rising edge.
- rain  input  8  rainfall percentage; values above IN_MAX are clamped to IN_MAX.
- soil  input  8  soil moisture percentage; values above IN_MAX are clamped to IN_MAX.
- risk  output  8  registered risk score; holds its value between computations.

Behaviour:
- Reset (asynchronous, `rst_n`=0): `risk`=0, FSM=IDLE, all internal registers 0. Reset asserted mid-computation aborts it; `risk` is 0 afterwards.
- FSM states: IDLE, FUZZ, RULE, ACC, DIV, DONE.
- IDLE: on an edge with `ef`=1, capture the clamped `rain`/`soil` and go to FUZZ.
- Busy: `ef` is ignored in every state except IDLE. There is no queueing.
- FUZZ (1 cycle): register the membership degrees (0..100) for each input x:
  - Low = 100 if x<=25; 150-2x if 25<x<75; 0 if x>=75.
  - Med = 100-2*|x-50| (0 at x=0 and x=100).
  - High = 0 if x<=25; 2x-50 if 25<x<75; 100 if x>=75.
- RULE (1 cycle): each rule strength = min(rain degree, soil degree). Class weights = max over the rules mapping to that class.
  - Rule map (rain,soil): LL→Low, LM→Low, ML→Low, LH→Med, MM→Med, HL→Med, MH→High, HM→High, HH→High.
  - Register wL, wM, wH (7 bits each).
- ACC (1 cycle):
  - num = wL*RISK_LOW + wM*RISK_MED + wH*RISK_HIGH (17-bit unsigned).
  - den = wL+wM+wH (9-bit).
  - Initialise the divider.
- DIV (17 cycles): restoring shift-subtract division, one quotient bit per cycle, MSB first. Quotient is truncated.
- DONE (1 cycle):
  - `risk` <= quotient, saturated at 255.
  - If den==0, `risk` <= 0 (defensive; unreachable with these membership functions).
  - Return to IDLE.
- Latency: `risk` updates on the 21st rising edge after the edge that sampled `ef` (FUZZ+RULE+ACC = 3, DIV = 17, DONE = 1). A new `ef` is accepted from the edge after DONE.
- `risk` changes only in DONE or on reset.
- Arithmetic: all unsigned; no intermediate overflow at the stated widths.

Test Plan:
- Reset: assert `rst_n`=0 asynchronously mid-DIV → `risk`=0 immediately; after release, no update occurs without a new `ef`.
- rain=10, soil=10, one-cycle `ef` → wL=100, wM=20, wH=0; `risk`=6560/120=54 on the 21st edge after the sample edge; `risk` holds 0 before that edge.
- rain=90, soil=90 → wL=0, wM=20, wH=100; `risk`=25560/120=213.
- rain=50, soil=50 → wL=50, wM=100, wH=50; `risk`=26300/200=131 (truncated).
- rain=0, soil=100 → only LH is active, weight 100; `risk`=128. Then rain=200, soil=255 (clamped to 100) → only HH is active; `risk`=230.
- Second `ef` pulse 5 cycles after the first, with different inputs → ignored; `risk` reflects only the first sample. An `ef` pulse after return to IDLE is accepted.

Source files
------------

// File: rtl/fuzzy_risk.sv
// Mamdani fuzzy risk core: rain/soil (0..100) -> risk (0..255).
// Ports: clk, rst_n (async low), ef (start), rain, soil, risk (registered).
module fuzzy_risk #(
  parameter int unsigned IN_MAX    = 100,
  parameter int unsigned RISK_LOW  = 40,
  parameter int unsigned RISK_MED  = 128,
  parameter int unsigned RISK_HIGH = 230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ef,
  input  logic [7:0] rain,
  input  logic [7:0] soil,
  output logic [7:0] risk
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FUZZ = 3'd1;
  localparam logic [2:0] S_RULE = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DIV  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [7:0] IN_CAP = 8'(IN_MAX);

  function automatic logic [6:0] mf_low(input logic [6:0] x);
    if (x <= 7'd25)
      return 7'd100;
    else if (x < 7'd75)
      return 7'(8'd150 - {x, 1'b0});
    else
      return 7'd0;
  endfunction

  function automatic logic [6:0] mf_med(input logic [6:0] x);
    logic [6:0] d;
    d = (x >= 7'd50) ? (x - 7'd50) : (7'd50 - x);
    return 7'(8'd100 - {d, 1'b0});
  endfunction

  function automatic logic [6:0] mf_high(input logic [6:0] x);
    if (x <= 7'd25)
      return 7'd0;
    else if (x < 7'd75)
      return 7'({x, 1'b0} - 8'd50);
    else
      return 7'd100;
  endfunction

  function automatic logic [6:0] min7(
    input logic [6:0] a,
    input logic [6:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [6:0] max3(
    input logic [6:0] a,
    input logic [6:0] b,
    input logic [6:0] c
  );
    logic [6:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic [2:0]  state;
  logic [6:0]  rain_q, soil_q;
  logic [6:0]  r_l, r_m, r_h;
  logic [6:0]  s_l, s_m, s_h;
  logic [6:0]  w_l, w_m, w_h;
  logic [8:0]  den;
  logic [16:0] quo;
  logic [8:0]  rem;
  logic [4:0]  cnt;

  logic [6:0]  rain_c, soil_c;
  logic [6:0]  nw_l, nw_m, nw_h;
  logic [16:0] num;
  logic [8:0]  den_n;
  logic [9:0]  rem_sh;
  logic        q_bit;

  assign rain_c = (rain > IN_CAP) ? 7'(IN_CAP) : rain[6:0];
  assign soil_c = (soil > IN_CAP) ? 7'(IN_CAP) : soil[6:0];

  always_comb begin
    nw_l = max3(min7(r_l, s_l), min7(r_l, s_m), min7(r_m, s_l));
    nw_m = max3(min7(r_l, s_h), min7(r_m, s_m), min7(r_h, s_l));
    nw_h = max3(min7(r_m, s_h), min7(r_h, s_m), min7(r_h, s_h));
  end

  assign num = 17'(w_l) * 17'(RISK_LOW)
             + 17'(w_m) * 17'(RISK_MED)
             + 17'(w_h) * 17'(RISK_HIGH);
  assign den_n = 9'(w_l) + 9'(w_m) + 9'(w_h);

  // Restoring step: quotient bits shift into quo as dividend bits leave.
  assign rem_sh = {rem, quo[16]};
  assign q_bit  = (rem_sh >= {1'b0, den});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rain_q <= '0;
      soil_q <= '0;
      r_l    <= '0;
      r_m    <= '0;
      r_h    <= '0;
      s_l    <= '0;
      s_m    <= '0;
      s_h    <= '0;
      w_l    <= '0;
      w_m    <= '0;
      w_h    <= '0;
      den    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      risk   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ef) begin
            rain_q <= rain_c;
            soil_q <= soil_c;
            state  <= S_FUZZ;
          end
        end
        S_FUZZ: begin
          r_l   <= mf_low(rain_q);
          r_m   <= mf_med(rain_q);
          r_h   <= mf_high(rain_q);
          s_l   <= mf_low(soil_q);
          s_m   <= mf_med(soil_q);
          s_h   <= mf_high(soil_q);
          state <= S_RULE;
        end
        S_RULE: begin
          w_l   <= nw_l;
          w_m   <= nw_m;
          w_h   <= nw_h;
          state <= S_ACC;
        end
        S_ACC: begin
          quo   <= num;
          den   <= den_n;
          rem   <= '0;
          cnt   <= 5'd16;
          state <= S_DIV;
        end
        S_DIV: begin
          rem   <= q_bit ? 9'(rem_sh - {1'b0, den}) : rem_sh[8:0];
          quo   <= {quo[15:0], q_bit};
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0)
            state <= S_DONE;
        end
        S_DONE: begin
          if (den == 9'd0)
            risk <= 8'd0;
          else if (|quo[16:8])
            risk <= 8'hff;
          else
            risk <= quo[7:0];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_risk.sv
// Scoreboard bench for fuzzy_risk.
// Driver queues expected results; monitor checks at the due edge.
module tb_fuzzy_risk;

  logic       clk;
  logic       rst_n;
  logic       ef;
  logic [7:0] rain;
  logic [7:0] soil;
  logic [7:0] risk;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int         due;
    logic [7:0] exp;
    logic [7:0] prev;
  } exp_t;

  exp_t q[$];
  logic [7:0] last_exp;

  fuzzy_risk dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ef   (ef),
    .rain (rain),
    .soil (soil),
    .risk (risk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: hold value on the edge before, result on the due edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (cyc == q[0].due - 1) begin
        chk("hold_before_done", risk, q[0].prev);
      end else if (cyc == q[0].due) begin
        chk("result", risk, q[0].exp);
        void'(q.pop_front());
      end else if (cyc > q[0].due) begin
        chk("missed_due", risk, q[0].exp);
        void'(q.pop_front());
      end
    end
  end

  // Called shortly after a negedge; the next posedge samples ef.
  task automatic issue(
    input logic [7:0] r,
    input logic [7:0] s,
    input logic [7:0] e
  );
    exp_t it;
    rain    = r;
    soil    = s;
    ef      = 1'b1;
    it.due  = cyc + 22;
    it.exp  = e;
    it.prev = last_exp;
    q.push_back(it);
    last_exp = e;
    @(negedge clk);
    #1;
    ef = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] r, input logic [7:0] s);
    rain = r;
    soil = s;
    ef   = 1'b1;
    @(negedge clk);
    #1;
    ef = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = 8'd0;
    rst_n    = 1'b0;
    ef       = 1'b0;
    rain     = 8'd0;
    soil     = 8'd0;
    #1;
    chk("reset_state", risk, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    issue(8'd10, 8'd10, 8'd54);
    wait_empty();
    issue(8'd90, 8'd90, 8'd213);
    wait_empty();
    issue(8'd50, 8'd50, 8'd131);
    wait_empty();
    issue(8'd0, 8'd100, 8'd128);
    wait_empty();
    issue(8'd200, 8'd255, 8'd230);
    wait_empty();

    // A second ef while busy must be dropped.
    issue(8'd10, 8'd10, 8'd54);
    repeat (4) @(negedge clk);
    #1;
    pulse(8'd90, 8'd90);
    wait_empty();
    repeat (25) @(negedge clk);
    #1;
    chk("busy_ef_ignored", risk, 8'd54);
    issue(8'd50, 8'd50, 8'd131);
    wait_empty();

    // Async reset in the middle of the division.
    issue(8'd90, 8'd90, 8'd213);
    repeat (9) @(negedge clk);
    q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", risk, 8'd0);
    last_exp = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("reset_no_update", risk, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
